// File: rtl/exc_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the EXC-stage hazard controller.
// Holds the FSM state encoding, the forward-select constants and the tracking-slot types.
package exc_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXC = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic v;
    logic wa;
    logic wb;
    logic ld;
  } exc_slot_t;

  typedef struct packed {
    logic v;
    logic wa;
    logic wb;
  } wb_slot_t;

  // EXC wins over WB. A load still in EXC has no result yet, so it cannot forward.
  function automatic logic [1:0] fwd_sel(input logic rd,
                                         input logic exc_v, input logic exc_wr, input logic exc_ld,
                                         input logic wb_v,  input logic wb_wr);
    if (rd && exc_v && exc_wr && !exc_ld) return FWD_EXC;
    if (rd && wb_v && wb_wr)              return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/exc_hazard_ctrl.sv
// Load-use stall, taken-branch flush and operand forward selection for the EXC stage.
// Tracks the instructions sitting in EXC and WB and counts load-use stalls.
module exc_hazard_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iValid_ID,
  input  logic             iRdA_ID,
  input  logic             iRdB_ID,
  input  logic             iWrA_ID,
  input  logic             iWrB_ID,
  input  logic             iLoad_ID,
  input  logic             iBranchTaken_EXC,
  output logic [1:0]       oFwdA,
  output logic [1:0]       oFwdB,
  output logic             oStall_ID,
  output logic             oFlush_ID,
  output logic [CNT_W-1:0] oStallCount
);
  import exc_hazard_ctrl_pkg::*;

  state_e             state_q, state_d;
  exc_slot_t          exc_q, exc_d;
  wb_slot_t           wb_q, wb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic br_live;
  logic hazard;
  logic stall;
  logic flush;
  logic fwd_ok;

  always_comb begin
    br_live = (state_q == ST_RUN) && iBranchTaken_EXC && exc_q.v;
    hazard  = (state_q == ST_RUN) && iValid_ID && exc_q.v && exc_q.ld &&
              ((iRdA_ID && exc_q.wa) || (iRdB_ID && exc_q.wb));
    // A taken branch kills the consumer anyway, so it suppresses the stall.
    stall   = hazard && !br_live;
    flush   = br_live || (state_q == ST_FLUSH);
    fwd_ok  = iValid_ID && !stall && !flush;

    oStall_ID = stall;
    oFlush_ID = flush;
    oFwdA = fwd_ok ? fwd_sel(iRdA_ID, exc_q.v, exc_q.wa, exc_q.ld, wb_q.v, wb_q.wa) : FWD_RF;
    oFwdB = fwd_ok ? fwd_sel(iRdB_ID, exc_q.v, exc_q.wb, exc_q.ld, wb_q.v, wb_q.wb) : FWD_RF;

    state_d = ST_RUN;
    if (state_q == ST_RUN) begin
      if (br_live)     state_d = ST_FLUSH;
      else if (hazard) state_d = ST_LDSTALL;
    end

    wb_d = '{v: exc_q.v, wa: exc_q.wa, wb: exc_q.wb};
    if (stall || flush) begin
      exc_d = '0;
    end else begin
      exc_d = '{v: iValid_ID, wa: iValid_ID && iWrA_ID, wb: iValid_ID && iWrB_ID,
                ld: iValid_ID && iLoad_ID};
    end

    cnt_d = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign oStallCount = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      exc_q   <= '0;
      wb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      wb_q    <= wb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_exc_hazard_ctrl.sv
// Self-checking bench for exc_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an instruction-level model.
module tb_exc_hazard_ctrl;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          iValid_ID, iRdA_ID, iRdB_ID, iWrA_ID, iWrB_ID, iLoad_ID, iBranchTaken_EXC;
  logic [1:0]    oFwdA, oFwdB;
  logic          oStall_ID, oFlush_ID;
  logic [CW-1:0] oStallCount;

  exc_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iValid_ID(iValid_ID), .iRdA_ID(iRdA_ID), .iRdB_ID(iRdB_ID),
    .iWrA_ID(iWrA_ID), .iWrB_ID(iWrB_ID), .iLoad_ID(iLoad_ID),
    .iBranchTaken_EXC(iBranchTaken_EXC),
    .oFwdA(oFwdA), .oFwdB(oFwdB), .oStall_ID(oStall_ID), .oFlush_ID(oFlush_ID),
    .oStallCount(oStallCount)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction-level model: ins[0] is what occupies EXC, ins[1] what occupies WB.
  // pending: 0 = nothing owed, 1 = the cycle after a stall, 2 = second flush cycle owed.
  typedef struct {bit v; bit wa; bit wb; bit ld;} ins_t;
  ins_t ins[2];
  int   pending = 0;
  int   stalls  = 0;

  function automatic int source(input bit rd, input bit is_a);
    bit w0, w1;
    w0 = is_a ? ins[0].wa : ins[0].wb;
    w1 = is_a ? ins[1].wa : ins[1].wb;
    if (!rd) return 0;
    if (ins[0].v && w0 && !ins[0].ld) return 1;
    if (ins[1].v && w1) return 2;
    return 0;
  endfunction

  function automatic void predict(output bit br, output bit hz, output bit st, output bit fl,
                                  output int fa, output int fb);
    br = (pending == 0) && iBranchTaken_EXC && ins[0].v;
    hz = (pending == 0) && iValid_ID && ins[0].v && ins[0].ld &&
         ((iRdA_ID && ins[0].wa) || (iRdB_ID && ins[0].wb));
    st = hz && !br;
    fl = br || (pending == 2);
    if (!iValid_ID || st || fl) begin
      fa = 0;
      fb = 0;
    end else begin
      fa = source(iRdA_ID, 1'b1);
      fb = source(iRdB_ID, 1'b0);
    end
  endfunction

  bit m_br, m_hz, m_st, m_fl;
  int m_fa, m_fb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins[0]  <= '{0, 0, 0, 0};
      ins[1]  <= '{0, 0, 0, 0};
      pending <= 0;
      stalls  <= 0;
    end else begin
      predict(m_br, m_hz, m_st, m_fl, m_fa, m_fb);
      ins[1] <= ins[0];
      if (m_st || m_fl) ins[0] <= '{0, 0, 0, 0};
      else              ins[0] <= '{iValid_ID, iWrA_ID, iWrB_ID, iLoad_ID};
      pending <= (pending != 0) ? 0 : (m_br ? 2 : (m_hz ? 1 : 0));
      if (m_st && stalls < CMAX) stalls <= stalls + 1;
    end
  end

  bit c_br, c_hz, c_st, c_fl;
  int c_fa, c_fb;
  always @(negedge clk) begin
    if (chk_en) begin
      predict(c_br, c_hz, c_st, c_fl, c_fa, c_fb);
      check("fwdA", int'(oFwdA), c_fa);
      check("fwdB", int'(oFwdB), c_fb);
      check("stall", int'(oStall_ID), int'(c_st));
      check("flush", int'(oFlush_ID), int'(c_fl));
      check("stall_count", int'(oStallCount), stalls);
    end
  end

  task automatic cyc(input bit v, input bit ra, input bit rb, input bit wa, input bit wb,
                     input bit ld, input bit br);
    @(posedge clk);
    #1;
    iValid_ID = v; iRdA_ID = ra; iRdB_ID = rb; iWrA_ID = wa; iWrB_ID = wb;
    iLoad_ID = ld; iBranchTaken_EXC = br;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    {iValid_ID, iRdA_ID, iRdB_ID, iWrA_ID, iWrB_ID, iLoad_ID, iBranchTaken_EXC} = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    {iValid_ID, iRdA_ID, iRdB_ID, iWrA_ID, iWrB_ID, iLoad_ID, iBranchTaken_EXC} = '0;
    #1 rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    check("reset_fwdA", int'(oFwdA), 0);
    check("reset_stall", int'(oStall_ID), 0);
    check("reset_flush", int'(oFlush_ID), 0);
    check("reset_count", int'(oStallCount), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // ALU chain: EXC forward then WB forward.
    cyc(1, 0, 0, 1, 0, 0, 0);
    check("alu_op1_fwdA", int'(oFwdA), 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("alu_op2_fwdA", int'(oFwdA), 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("alu_op3_fwdA", int'(oFwdA), 2);

    // Load B then use B.
    do_reset();
    cyc(1, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    check("ldu_stall", int'(oStall_ID), 1);
    check("ldu_fwdB_forced", int'(oFwdB), 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    check("ldu_after_stall", int'(oStall_ID), 0);
    check("ldu_fwdB_wb", int'(oFwdB), 2);
    check("ldu_count", int'(oStallCount), 1);

    // Taken branch with valid EXC: two flush cycles, then EXC is a bubble.
    do_reset();
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 1);
    check("br_flush1", int'(oFlush_ID), 1);
    check("br_fwdA1", int'(oFwdA), 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("br_flush2", int'(oFlush_ID), 1);
    check("br_fwdA2", int'(oFwdA), 0);
    cyc(1, 1, 0, 0, 0, 0, 1);
    check("br_bubble_noflush", int'(oFlush_ID), 0);
    check("br_bubble_fwdA", int'(oFwdA), 0);

    // Branch and load-use hazard together: branch wins.
    do_reset();
    cyc(1, 0, 0, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0, 1);
    check("brld_stall", int'(oStall_ID), 0);
    check("brld_flush", int'(oFlush_ID), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("brld_count", int'(oStallCount), 0);

    // Reset in the middle of LDSTALL.
    do_reset();
    cyc(1, 0, 0, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("rst_mid_stall", int'(oStall_ID), 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("rst_mid_fwdA_pre", int'(oFwdA), 2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_fwdA", int'(oFwdA), 0);
    check("rst_mid_count", int'(oStallCount), 0);
    check("rst_mid_flush", int'(oFlush_ID), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("rst_after_fwdA", int'(oFwdA), 0);
    check("rst_after_stall", int'(oStall_ID), 0);

    // Saturation of the stall counter.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 0, 0, 1, 1, 0);
      cyc(1, 0, 1, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("sat_count", int'(oStallCount), 255);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_hazard_ctrl.md
EXC_HAZARD_CTRL -- requirements
Module: exc_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating stall counter.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 iValid_ID  input  1  ID stage holds a real instruction.
REQ-005 iRdA_ID / iRdB_ID  input  1 each  ID instruction reads Reg A / Reg B, including its carry.
REQ-006 iWrA_ID / iWrB_ID  input  1 each  ID instruction writes Reg A / Reg B, including its carry.
REQ-007 iLoad_ID  input  1  ID instruction is a memory load; its result is valid only in WB.
REQ-008 iBranchTaken_EXC  input  1  the instruction in EXC resolved as a taken branch.
REQ-009 oFwdA / oFwdB  output  2 each  operand source for EXC: 0 = register file, 1 = EXC result (oResult/oCarry), 2 = WB result; 3 is never driven.
REQ-010 oStall_ID  output  1  hold the ID stage; insert a bubble into EXC.
REQ-011 oFlush_ID  output  1  kill the ID instruction.
REQ-012 oStallCount  output  CNT_W  count of load-use stalls, saturating.

Function
REQ-013 Internal tracking slots: EXC slot {v, wa, wb, ld} and WB slot {v, wa, wb}.
REQ-014 Normal advance, with no stall and no flush: EXC slot <= ID info gated by iValid_ID; WB slot <= EXC slot.
REQ-015 Stall or flush: EXC slot <= bubble (v=0); WB slot <= EXC slot.
REQ-016 FSM states: RUN, LDSTALL, FLUSH.
REQ-017 Load-use hazard (combinational): state RUN, iValid_ID, EXC.v, EXC.ld, and (iRdA_ID & EXC.wa | iRdB_ID & EXC.wb).
REQ-018 RUN transitions: iBranchTaken_EXC & EXC.v -> FLUSH; else hazard -> LDSTALL; else stay in RUN.
REQ-019 LDSTALL and FLUSH each last exactly one cycle, then return to RUN.
REQ-020 oStall_ID = 1 only in RUN with a hazard and no taken branch; it is never asserted in LDSTALL or FLUSH.
REQ-021 oFlush_ID = 1 in RUN when iBranchTaken_EXC & EXC.v, and for the whole FLUSH cycle.
REQ-022 Branch wins over a simultaneous load-use hazard: no stall, no counter increment.
REQ-023 oFwdA selection, combinational: 1 if iRdA_ID & EXC.v & EXC.wa & !EXC.ld; else 2 if iRdA_ID & WB.v & WB.wa; else 0.
REQ-024 oFwdB follows the same rule using the rd/wr B signals.
REQ-025 EXC has priority over WB; oFwdA/oFwdB are forced to 0 while oFlush_ID or oStall_ID = 1, or when iValid_ID = 0.
REQ-026 In LDSTALL the load sits in WB, so the stalled consumer receives oFwd = 2 from the same register.
REQ-027 Operand latency: the forward select is valid in the same cycle the ID info is presented; the tracking slots update on the next edge.
REQ-028 oStallCount increments by 1 on each cycle with oStall_ID = 1 and holds at 2^CNT_W - 1.
REQ-029 An iBranchTaken_EXC arriving with EXC.v = 0 is ignored.

Reset
REQ-030 Reset low asynchronously forces: state = RUN, all slot valid bits = 0, oStallCount = 0.
REQ-031 During reset, oFwdA = oFwdB = 0, oStall_ID = 0, oFlush_ID = 0.
REQ-032 Reset asserted mid-LDSTALL or mid-FLUSH abandons the sequence; the first cycle after release behaves as RUN with empty slots.

Structure
REQ-033 The FSM state encoding and the forward-select constants (FWD_RF=0, FWD_EXC=1, FWD_WB=2) are defined in the shared pipeline definitions file, next to the opcode macros.
REQ-034 The block is a single module with no sub-modules; the forward-select logic is written once and instanced for A and B as a function.

Verification
REQ-035 Back-to-back ALU ops: op1 writes A, op2 reads A -> oFwdA = 1 for op2; a third op reading A one cycle later -> oFwdA = 2.
REQ-036 Load writes B, next op reads B -> oStall_ID = 1 for one cycle, LDSTALL follows with oFwdB = 2, oStallCount = 1.
REQ-037 iBranchTaken_EXC = 1 while EXC.v = 1 -> oFlush_ID = 1 for two consecutive cycles, forward selects = 0, EXC slot is a bubble afterward.
REQ-038 Taken branch in the same cycle as a load-use hazard -> oStall_ID = 0, oFlush_ID = 1, oStallCount unchanged.
REQ-039 300 consecutive load-use pairs with CNT_W = 8 -> oStallCount saturates at 255.
REQ-040 Reset pulled low during LDSTALL -> outputs go to 0 immediately; after release, an op reading A gets oFwdA = 0.
